// File: rtl/data_sram_resp.sv
// data_sram_resp: responder for the core's data SRAM port.
// Word-addressed backing RAM with a multi-cycle write port, fronted by a
// small FIFO store buffer. Loads complete in one cycle with byte-wise
// forwarding from every pending store; stores retire into the buffer and
// are drained to the RAM one at a time in the background.
module data_sram_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WB_DEPTH    = 4,
  parameter int unsigned WR_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      data_sram_en,
  input  logic [3:0]                data_sram_wen,
  input  logic [31:0]               data_sram_addr,
  input  logic [31:0]               data_sram_wdata,
  output logic [31:0]               data_sram_rdata,
  output logic                      stallreq,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = $clog2(WR_LAT + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [PW:0]     count_q;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   wb_idx [WB_DEPTH];
  logic [3:0]      wb_be  [WB_DEPTH];
  logic [31:0]     wb_dat [WB_DEPTH];

  logic [AW-1:0]   dr_idx;
  logic [3:0]      dr_be;
  logic [31:0]     dr_dat;

  logic [AW-1:0]   ridx;
  logic            is_load, is_store, full, commit;
  logic            stall, start, enq, load_acc;
  logic [31:0]     fwd;
  logic            unused_addr;

  assign ridx        = data_sram_addr[AW+1:2];
  assign unused_addr = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};
  assign is_load     = data_sram_en && (data_sram_wen == 4'b0000);
  assign is_store    = data_sram_en && (data_sram_wen != 4'b0000);
  assign full        = (count_q == (PW+1)'(WB_DEPTH));
  assign commit      = (state_q == DRAIN) && (cnt_q == '0);
  assign enq         = is_store && !stall;
  assign load_acc    = is_load && (state_q == IDLE);

  assign stallreq    = stall && resetn;
  assign wb_count    = count_q;
  assign wb_empty    = (count_q == '0);

  // Drain FSM next state, drain start and request acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 && !is_load) begin
          start   = 1'b1;
          state_d = DRAIN;
          cnt_d   = CW'(WR_LAT - 1);
        end
        if (is_store && full) stall = 1'b1;
      end
      DRAIN: begin
        if (commit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (is_load) stall = 1'b1;
        else if (is_store && full && !commit) stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data: RAM word overlaid by pending stores, oldest first so the newest byte wins.
  always_comb begin
    logic [PW-1:0] pos;
    fwd = mem[ridx];
    pos = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      pos = head_q + i[PW-1:0];
      if (i < 32'(count_q) && wb_idx[pos] == ridx) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wb_be[pos][b]) fwd[8*b +: 8] = wb_dat[pos][8*b +: 8];
        end
      end
    end
  end

  // Control state, buffer pointers/occupancy and registered load data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      data_sram_rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enq)    tail_q <= tail_q + 1'b1;
      if (commit) head_q <= head_q + 1'b1;
      unique case ({enq, commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (load_acc) data_sram_rdata <= fwd;
    end
  end

  // Store-buffer entry payloads and the latched head entry being drained.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[tail_q] <= ridx;
      wb_be[tail_q]  <= data_sram_wen;
      wb_dat[tail_q] <= data_sram_wdata;
    end
    if (start) begin
      dr_idx <= wb_idx[head_q];
      dr_be  <= wb_be[head_q];
      dr_dat <= wb_dat[head_q];
    end
  end

  // Backing RAM write port: byte-masked commit of the drained entry.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (dr_be[b]) mem[dr_idx][8*b +: 8] <= dr_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed testbench for data_sram_resp (default parameters).
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int checks = 0;
  int errors = 0;

  data_sram_resp #(.DEPTH_WORDS(1024), .WB_DEPTH(4), .WR_LAT(2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .wb_count        (wb_count),
    .wb_empty        (wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic stall, input logic [31:0] rdata,
                     input logic [2:0] cnt);
    vecs[nvec].en    = en;
    vecs[nvec].wen   = wen;
    vecs[nvec].addr  = addr;
    vecs[nvec].wdata = wdata;
    vecs[nvec].stall = stall;
    vecs[nvec].rdata = rdata;
    vecs[nvec].cnt   = cnt;
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request cycle: drive at negedge, check stall mid-cycle, check state after the edge.
  task automatic step(input string nm, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic stall, input logic [31:0] rdata, input logic [2:0] cnt);
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    #2;
    chk({nm, " stallreq"}, 32'(stallreq), 32'(stall));
    @(posedge clk);
    #1;
    chk({nm, " rdata"}, data_sram_rdata, rdata);
    chk({nm, " wb_count"}, 32'(wb_count), 32'(cnt));
    chk({nm, " wb_empty"}, 32'(wb_empty), 32'(cnt == 3'd0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Main sequence: forwarding, merge, full-buffer stores, loads during drain, drain-out.
    add(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1);
    add(1, 4'h0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0);
    add(1, 4'hF, 32'h20, 32'h11223344, 0, 32'hDEADBEEF, 1);
    add(1, 4'h1, 32'h20, 32'h000000AA, 0, 32'hDEADBEEF, 2);
    add(1, 4'h4, 32'h22, 32'h00BB0000, 0, 32'hDEADBEEF, 3);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 2);
    add(1, 4'h0, 32'h20, 32'h0,        0, 32'h11BB33AA, 2);
    add(1, 4'h0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2);
    add(1, 4'hF, 32'h30, 32'hCAFEF00D, 0, 32'hDEADBEEF, 3);
    add(1, 4'hF, 32'h34, 32'h01020304, 0, 32'hDEADBEEF, 4);
    add(1, 4'hF, 32'h38, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 4);
    add(1, 4'hF, 32'h3C, 32'h5A5A5A5A, 1, 32'hDEADBEEF, 4);
    add(1, 4'hF, 32'h3C, 32'h5A5A5A5A, 1, 32'hDEADBEEF, 4);
    add(1, 4'hF, 32'h3C, 32'h5A5A5A5A, 0, 32'hDEADBEEF, 4);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 4);
    add(1, 4'h0, 32'h20, 32'h0,        1, 32'hDEADBEEF, 4);
    add(1, 4'h0, 32'h20, 32'h0,        1, 32'hDEADBEEF, 3);
    add(1, 4'h0, 32'h20, 32'h0,        0, 32'h11BB33AA, 3);
    add(1, 4'h0, 32'h30, 32'h0,        0, 32'hCAFEF00D, 3);
    add(1, 4'h0, 32'h38, 32'h0,        0, 32'hA5A5A5A5, 3);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 3);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 3);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 2);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 2);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 2);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 1);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 0);
    add(0, 4'h0, 32'h0,  32'h0,        0, 32'hA5A5A5A5, 0);
    add(1, 4'h0, 32'h34, 32'h0,        0, 32'h01020304, 0);
    add(1, 4'h0, 32'h3C, 32'h0,        0, 32'h5A5A5A5A, 0);
    add(1, 4'h0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0);

    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata", data_sram_rdata, 32'h0);
    chk("reset wb_count", 32'(wb_count), 32'd0);
    chk("reset wb_empty", 32'(wb_empty), 32'd1);
    chk("reset stallreq", 32'(stallreq), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
           vecs[i].stall, vecs[i].rdata, vecs[i].cnt);
    end

    // Reset while a drain is one edge from committing: the RAM word must keep its prior value.
    step("r0", 1, 4'hF, 32'h40, 32'hA0A0A0A0, 0, 32'hDEADBEEF, 1);
    step("r1", 0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1);
    step("r2", 0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1);
    step("r3", 0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0);
    step("r4", 1, 4'hF, 32'h40, 32'h11111111, 0, 32'hDEADBEEF, 1);
    step("r5", 1, 4'hF, 32'h44, 32'h22222222, 0, 32'hDEADBEEF, 2);
    step("r6", 1, 4'hF, 32'h48, 32'h33333333, 0, 32'hDEADBEEF, 3);
    @(negedge clk);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = 32'h40;
    #1;
    chk("drain load stallreq", 32'(stallreq), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midreset stallreq", 32'(stallreq), 32'd0);
    chk("midreset wb_count", 32'(wb_count), 32'd0);
    chk("midreset wb_empty", 32'(wb_empty), 32'd1);
    chk("midreset rdata", data_sram_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("midreset hold rdata", data_sram_rdata, 32'h0);
    @(negedge clk);
    data_sram_en = 1'b0;
    resetn       = 1'b1;
    step("post0", 1, 4'h0, 32'h40, 32'h0, 0, 32'hA0A0A0A0, 0);
    step("post1", 1, 4'h0, 32'h20, 32'h0, 0, 32'h11BB33AA, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
